multi_ultrasonic_scanner: RTL and testbench

- N-channel ultrasonic ranging controller that fires the HC-SR04-class sensors one at a time in round-robin order, so there is no acoustic crosstalk between sensors.
- For each channel it measures the echo pulse width in clock cycles and compares it against a runtime threshold to produce a per-channel obstacle flag.
- Sits between the sensor pins and the navigation/steering logic, replacing fixed three-sensor instantiation.

---
 rtl/ultrasonic_pkg.sv | 21 ++
 rtl/echo_sync.sv | 37 +++
 rtl/multi_ultrasonic_scanner.sv | 188 ++++++++++++++++++
 tb/tb_multi_ultrasonic_scanner.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing for the ultrasonic ranging blocks (100 MHz clock).
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        GAP       = 3'd4
    } scan_state_t;

    localparam int DEF_N_CH        = 3;
    localparam int DEF_CNT_W       = 22;
    localparam int DEF_TRIG_CYC    = 1000;     // 10 us trigger
    localparam int DEF_TIMEOUT_CYC = 3000000;  // 30 ms echo limit
    localparam int DEF_GAP_CYC     = 6000000;  // 60 ms dead time between channels

    // Round-trip echo cycles per centimetre, for downstream distance conversion.
    localparam int CYC_PER_CM      = 5800;

endpackage

// File: rtl/echo_sync.sv
// N-wide 2-FF synchroniser for asynchronous echo pins with rising/falling edge detect.
module echo_sync
    import ultrasonic_pkg::*;
#(
    parameter int N_CH = DEF_N_CH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);

    logic [N_CH-1:0] sync_a;
    logic [N_CH-1:0] sync_b;
    logic [N_CH-1:0] sync_prev;

    // Two metastability stages plus one history stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a    <= '0;
            sync_b    <= '0;
            sync_prev <= '0;
        end else begin
            sync_a    <= din;
            sync_b    <= sync_a;
            sync_prev <= sync_b;
        end
    end

    // Edges are taken on the synchronised level only.
    always_comb begin
        rise = sync_b & ~sync_prev;
        fall = ~sync_b & sync_prev;
    end

endmodule

// File: rtl/multi_ultrasonic_scanner.sv
// Round-robin N-channel ultrasonic ranging controller: one sensor fired at a time,
// echo width measured in cycles and compared against a runtime obstacle threshold.
module multi_ultrasonic_scanner
    import ultrasonic_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TRIG_CYC    = DEF_TRIG_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int GAP_CYC     = DEF_GAP_CYC
) (
    input  logic                  fpgaclk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       pulse,
    input  logic [CNT_W-1:0]      threshold,
    input  logic                  enable,
    output logic [N_CH-1:0]       triggerout,
    output logic [N_CH-1:0]       obstacle,
    output logic [N_CH*CNT_W-1:0] echo_width,
    output logic [N_CH-1:0]       timeout,
    output logic                  meas_valid,
    output logic [2:0]            meas_ch
);

    // TRIG and GAP share one timer; GAP_CYC can exceed the echo counter range.
    localparam int TMR_MAX = (GAP_CYC > TRIG_CYC) ? GAP_CYC : TRIG_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIG_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LIMIT  = CNT_W'(TIMEOUT_CYC);

    scan_state_t       state;
    logic [2:0]        ch;
    logic [2:0]        ch_next;
    logic [N_CH-1:0]   ch_oh;
    logic [N_CH-1:0]   ch_next_oh;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [TMR_W-1:0]  tmr;
    logic [N_CH-1:0]   rise;
    logic [N_CH-1:0]   fall;
    logic              rise_sel;
    logic              fall_sel;
    logic              res_wr;
    logic              res_to;
    logic              res_obst;
    logic [CNT_W-1:0]  res_width;

    function automatic logic [N_CH-1:0] ch_onehot(input logic [2:0] c);
        logic [N_CH-1:0] oh;
        oh = '0;
        for (int k = 0; k < N_CH; k++) begin
            oh[k] = (c == 3'(k));
        end
        return oh;
    endfunction

    echo_sync #(
        .N_CH (N_CH)
    ) u_echo_sync (
        .clk  (fpgaclk),
        .rst  (rst),
        .din  (pulse),
        .rise (rise),
        .fall (fall)
    );

    // Channel select, edge mux and result decision for the active channel.
    always_comb begin
        ch_next    = (ch == 3'(N_CH - 1)) ? 3'd0 : ch + 3'd1;
        ch_oh      = ch_onehot(ch);
        ch_next_oh = ch_onehot(ch_next);
        rise_sel   = |(rise & ch_oh);
        fall_sel   = |(fall & ch_oh);
        cnt_inc    = cnt + CNT_W'(1);
        res_wr     = 1'b0;
        res_to     = 1'b0;
        res_width  = cnt_inc;
        if (state == WAIT_RISE && !rise_sel && cnt_inc == TO_LIMIT) begin
            res_wr    = 1'b1;
            res_to    = 1'b1;
            res_width = TO_LIMIT;
        end
        if (state == MEASURE) begin
            // The rise cycle is the first high cycle, so the width is cnt+1 at the fall.
            if (fall_sel) begin
                res_wr = 1'b1;
            end else if (cnt_inc == TO_LIMIT) begin
                res_wr    = 1'b1;
                res_to    = 1'b1;
                res_width = TO_LIMIT;
            end
        end
        res_obst = !res_to && (res_width < threshold);
    end

    // Scan sequencer: trigger, wait for echo, measure, dead time, next channel.
    always_ff @(posedge fpgaclk) begin
        if (rst) begin
            state      <= IDLE;
            ch         <= 3'd0;
            cnt        <= '0;
            tmr        <= '0;
            triggerout <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state      <= TRIG;
                        tmr        <= '0;
                        triggerout <= ch_oh;
                    end
                end
                TRIG: begin
                    if (tmr == TRIG_LAST) begin
                        triggerout <= '0;
                        cnt        <= '0;
                        state      <= WAIT_RISE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                WAIT_RISE: begin
                    if (rise_sel) begin
                        cnt   <= '0;
                        state <= MEASURE;
                    end else if (res_wr) begin
                        tmr   <= '0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                MEASURE: begin
                    if (res_wr) begin
                        tmr   <= '0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                GAP: begin
                    if (tmr == GAP_LAST) begin
                        ch  <= ch_next;
                        tmr <= '0;
                        if (enable) begin
                            triggerout <= ch_next_oh;
                            state      <= TRIG;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                default: begin
                    triggerout <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Per-channel result registers; only the active channel is written.
    always_ff @(posedge fpgaclk) begin
        if (rst) begin
            echo_width <= '0;
            obstacle   <= '0;
            timeout    <= '0;
            meas_valid <= 1'b0;
            meas_ch    <= 3'd0;
        end else begin
            meas_valid <= res_wr;
            if (res_wr) begin
                meas_ch <= ch;
                for (int k = 0; k < N_CH; k++) begin
                    if (ch_oh[k]) begin
                        echo_width[k*CNT_W +: CNT_W] <= res_width;
                        obstacle[k]                  <= res_obst;
                        timeout[k]                   <= res_to;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_ultrasonic_scanner.sv
// Directed bench for multi_ultrasonic_scanner with short timing parameters.
module tb_multi_ultrasonic_scanner;

    localparam int N_CH        = 3;
    localparam int CNT_W       = 12;
    localparam int TRIG_CYC    = 4;
    localparam int TIMEOUT_CYC = 200;
    localparam int GAP_CYC     = 10;

    logic                  fpgaclk = 1'b0;
    logic                  rst;
    logic                  enable;
    logic [N_CH-1:0]       pulse;
    logic [CNT_W-1:0]      threshold;
    logic [N_CH-1:0]       triggerout;
    logic [N_CH-1:0]       obstacle;
    logic [N_CH*CNT_W-1:0] echo_width;
    logic [N_CH-1:0]       timeout;
    logic                  meas_valid;
    logic [2:0]            meas_ch;

    int n_assert = 0;
    int n_fail   = 0;
    int n;
    bit seen_trig;
    bit seen_valid;

    always #5 fpgaclk = ~fpgaclk;

    multi_ultrasonic_scanner #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .TRIG_CYC    (TRIG_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .GAP_CYC     (GAP_CYC)
    ) dut (
        .fpgaclk    (fpgaclk),
        .rst        (rst),
        .pulse      (pulse),
        .threshold  (threshold),
        .enable     (enable),
        .triggerout (triggerout),
        .obstacle   (obstacle),
        .echo_width (echo_width),
        .timeout    (timeout),
        .meas_valid (meas_valid),
        .meas_ch    (meas_ch)
    );

    task automatic tick();
        @(posedge fpgaclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int bound, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (meas_valid !== 1'b1 && cnt < bound);
        chk("meas_valid_seen", 64'(meas_valid), 64'(1));
    endtask

    task automatic wait_trig(input int bound, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (triggerout === 3'b000 && cnt < bound);
    endtask

    // Called on the first sample with the trigger high: checks the 4-cycle trigger,
    // then drives an echo on the channels in mask starting 5 cycles after it falls.
    task automatic fire(input logic [2:0] mask, input int width);
        repeat (3) begin
            tick();
            chk("trig_hold", 64'(triggerout), 64'(mask));
        end
        tick();
        chk("trig_fall", 64'(triggerout), 64'(0));
        repeat (4) tick();
        pulse = pulse | mask;
        repeat (width) tick();
        pulse = pulse & ~mask;
    endtask

    // Called on the meas_valid sample: strobe is one cycle, next trigger after the gap.
    task automatic next_pass(input logic [2:0] exp_trig);
        int g;
        tick();
        chk("strobe_one_cycle", 64'(meas_valid), 64'(0));
        wait_trig(50, g);
        chk("gap_len", 64'(g), 64'(9));
        chk("next_trig", 64'(triggerout), 64'(exp_trig));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        pulse     = '0;
        threshold = 12'd50;
        repeat (3) tick();
        chk("rst_trig",    64'(triggerout), 64'(0));
        chk("rst_obst",    64'(obstacle),   64'(0));
        chk("rst_width",   64'(echo_width), 64'(0));
        chk("rst_timeout", 64'(timeout),    64'(0));
        chk("rst_valid",   64'(meas_valid), 64'(0));
        chk("rst_ch",      64'(meas_ch),    64'(0));

        // Pass 1: ch0, 30-cycle echo -> obstacle
        rst    = 1'b0;
        enable = 1'b1;
        tick();
        chk("trig_first", 64'(triggerout), 64'(3'b001));
        fire(3'b001, 30);
        chk("pre_result_obst",  64'(obstacle),   64'(0));
        chk("pre_result_width", 64'(echo_width), 64'(0));
        chk("pre_result_to",    64'(timeout),    64'(0));
        wait_valid(60, n);
        chk("p1_ch",    64'(meas_ch),           64'(0));
        chk("p1_width", 64'(echo_width[0 +: 12]), 64'(30));
        chk("p1_obst",  64'(obstacle),          64'(3'b001));
        chk("p1_to",    64'(timeout),           64'(3'b000));
        next_pass(3'b010);

        // Pass 2: ch1, width equal to threshold -> no obstacle
        fire(3'b010, 50);
        wait_valid(60, n);
        chk("p2_ch",     64'(meas_ch),            64'(1));
        chk("p2_width",  64'(echo_width[12 +: 12]), 64'(50));
        chk("p2_obst",   64'(obstacle),           64'(3'b001));
        chk("p2_keep0",  64'(echo_width[0 +: 12]),  64'(30));
        next_pass(3'b100);

        // Pass 3: ch2, no echo -> timeout after 4 trigger + 200 wait cycles
        wait_valid(300, n);
        chk("p3_latency", 64'(n),                   64'(204));
        chk("p3_ch",      64'(meas_ch),             64'(2));
        chk("p3_to",      64'(timeout),             64'(3'b100));
        chk("p3_width",   64'(echo_width[24 +: 12]), 64'(200));
        chk("p3_obst",    64'(obstacle),            64'(3'b001));
        next_pass(3'b001);

        // Pass 4: ch0, long echo -> clears ch0 obstacle
        fire(3'b001, 100);
        wait_valid(60, n);
        chk("p4_width", 64'(echo_width[0 +: 12]), 64'(100));
        chk("p4_obst",  64'(obstacle),          64'(3'b000));
        chk("p4_to",    64'(timeout),           64'(3'b100));
        next_pass(3'b010);

        // Pass 5: ch1, one below threshold -> obstacle
        fire(3'b010, 49);
        wait_valid(60, n);
        chk("p5_width", 64'(echo_width[12 +: 12]), 64'(49));
        chk("p5_obst",  64'(obstacle),           64'(3'b010));
        next_pass(3'b100);

        // Pass 6: ch2 echo stays high past the limit -> timeout in MEASURE
        repeat (8) tick();
        pulse = 3'b100;
        wait_valid(400, n);
        pulse = 3'b000;
        chk("p6_ch",    64'(meas_ch),             64'(2));
        chk("p6_to",    64'(timeout),             64'(3'b100));
        chk("p6_width", 64'(echo_width[24 +: 12]), 64'(200));
        chk("p6_obst",  64'(obstacle),            64'(3'b010));
        next_pass(3'b001);

        // Pass 7: ch0 short echo
        fire(3'b001, 20);
        wait_valid(60, n);
        chk("p7_width", 64'(echo_width[0 +: 12]), 64'(20));
        chk("p7_obst",  64'(obstacle),          64'(3'b011));
        next_pass(3'b010);

        // Pass 8: reset while ch1 is measuring
        repeat (8) tick();
        pulse = 3'b010;
        repeat (10) tick();
        rst   = 1'b1;
        pulse = 3'b000;
        tick();
        chk("mid_rst_trig",  64'(triggerout), 64'(0));
        chk("mid_rst_obst",  64'(obstacle),   64'(0));
        chk("mid_rst_to",    64'(timeout),    64'(0));
        chk("mid_rst_width", 64'(echo_width), 64'(0));
        chk("mid_rst_valid", 64'(meas_valid), 64'(0));
        chk("mid_rst_ch",    64'(meas_ch),    64'(0));
        tick();
        chk("mid_rst_valid2", 64'(meas_valid), 64'(0));
        rst = 1'b0;
        tick();
        chk("restart_ch0", 64'(triggerout), 64'(3'b001));

        // Pass 9: enable drops during TRIG, ch2 chatter while ch0 measures
        tick();
        enable = 1'b0;
        chk("en_low_trig_hold", 64'(triggerout), 64'(3'b001));
        repeat (2) tick();
        chk("en_low_trig_hold2", 64'(triggerout), 64'(3'b001));
        tick();
        chk("en_low_trig_fall", 64'(triggerout), 64'(0));
        repeat (4) tick();
        pulse = 3'b001;
        repeat (10) tick();
        pulse = 3'b101;
        repeat (10) tick();
        pulse = 3'b001;
        repeat (20) tick();
        pulse = 3'b000;
        wait_valid(60, n);
        chk("p9_ch",     64'(meas_ch),             64'(0));
        chk("p9_width",  64'(echo_width[0 +: 12]),  64'(40));
        chk("p9_obst",   64'(obstacle),            64'(3'b001));
        chk("p9_to",     64'(timeout),             64'(3'b000));
        chk("p9_width2", 64'(echo_width[24 +: 12]), 64'(0));
        seen_trig  = 1'b0;
        seen_valid = 1'b0;
        repeat (40) begin
            tick();
            if (triggerout !== 3'b000) seen_trig = 1'b1;
            if (meas_valid !== 1'b0)   seen_valid = 1'b1;
        end
        chk("idle_no_trig",  64'(seen_trig),  64'(0));
        chk("idle_no_valid", 64'(seen_valid), 64'(0));
        chk("idle_ch",       64'(meas_ch),    64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
